tick_countdown: RTL and testbench
=================================

TICK_COUNTDOWN -- requirements
Module: tick_countdown

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on slow_clk (min 2).
REQ-002 SHALL have port clk_in  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port slow_clk  input  1  divided clock from the clock divider, treated as asynchronous.
REQ-005 SHALL have port load  input  1  load preset into count, return to IDLE.
REQ-006 SHALL have port preset_min  input  8  minutes preset, two BCD digits [7:4] tens, [3:0] units.
REQ-007 SHALL have port preset_sec  input  8  seconds preset, two BCD digits.
REQ-008 SHALL have port start  input  1  level, sampled each cycle; begin/resume countdown.
REQ-009 SHALL have port stop  input  1  level, sampled each cycle; pause countdown.
REQ-010 SHALL have port min_bcd  output  8  current minutes, BCD.
REQ-011 SHALL have port sec_bcd  output  8  current seconds, BCD.
REQ-012 SHALL have port running  output  1  high while in state RUN.
REQ-013 SHALL have port done  output  1  high while in state DONE.
REQ-014 SHALL have port tick  output  1  registered one-cycle pulse per slow_clk rising edge.

Function
REQ-015 SHALL pass slow_clk through SYNC_STAGES flops, then one history flop; tick registered high for exactly one clk_in cycle when last sync stage is 1 and history is 0.
REQ-016 SHALL assert tick SYNC_STAGES+1 clk_in edges after the first edge sampling slow_clk high; slow_clk high/low phases each SHALL be at least SYNC_STAGES+1 cycles for no missed ticks.
REQ-017 SHALL implement states IDLE, RUN, PAUSE, DONE.
REQ-018 SHALL give per-cycle priority load > stop > start > tick.
REQ-019 On load (any state): count <= clamped preset, state <= IDLE, done cleared next cycle.
REQ-020 SHALL clamp preset digits: seconds tens >5 -> 5; any other digit >9 -> 9.
REQ-021 IDLE or PAUSE + start: if count != 00:00 -> RUN, else -> DONE.
REQ-022 RUN + stop -> PAUSE; a tick in the same cycle SHALL be discarded.
REQ-023 RUN + tick (no load/stop): count decremented by one second on that edge; when result is 00:00 state -> DONE on the same edge.
REQ-024 Decrement SHALL be BCD: sec units 0 borrows from sec tens (units -> 9); sec 00 borrows one minute (sec -> 59); minute digits borrow likewise (units 0 -> 9, tens decremented).
REQ-025 Count SHALL never wrap below 00:00; ticks in IDLE, PAUSE, DONE SHALL leave count unchanged.
REQ-026 DONE SHALL be left only by load or reset; start/stop ignored in DONE.
REQ-027 Outputs min_bcd, sec_bcd, running, done, tick SHALL be registered.

Reset
REQ-028 On rst_n low: state IDLE, min_bcd 8'h00, sec_bcd 8'h00, running 0, done 0, tick 0, sync and history flops 0.
REQ-029 Reset mid-RUN SHALL abort immediately without pulses; slow_clk high at release SHALL yield one tick (ignored in IDLE).

Structure
REQ-030 SHALL place the state enum, BCD max-digit constants (9, 5) and clamp/decrement widths in shared package egg_timer_pkg.
REQ-031 SHALL factor synchronizer + rising-edge pulse into sub-module edge_sync (params SYNC_STAGES), reused by other egg-timer inputs.

Verification
REQ-032 load preset 01:05, start, 6 slow_clk rises -> sec_bcd 05,04,03,02,01,00 then min 00 sec 59 after 6th tick; running stays 1.
REQ-033 preset 00:02, start, 2 rises -> after 2nd tick count 00:00, done=1, running=0 same edge; further rises keep 00:00.
REQ-034 RUN at 00:10, assert stop in the tick cycle -> state PAUSE, count stays 00:10; start -> RUN, next tick -> 00:09.
REQ-035 preset_min 8'hAB, preset_sec 8'h7C, load -> min_bcd 8'h99, sec_bcd 8'h59; preset 00:00 + start -> done=1 directly.
REQ-036 slow_clk rise, count clk_in edges to tick -> tick on edge SYNC_STAGES+1, width exactly 1 cycle; rst_n low mid-RUN -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/egg_timer_pkg.sv
// egg_timer_pkg: shared state encoding, BCD limits and clamp/decrement helpers for the egg timer
package egg_timer_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  localparam int DIGIT_W = 4;
  localparam int BCD_W = 2 * DIGIT_W;
  localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;
  localparam logic [DIGIT_W-1:0] MAX_TENS = 4'd5;
  function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d, input logic [DIGIT_W-1:0] lim);
    return (d > lim) ? lim : d;
  endfunction
  // Decrements mm:ss by one second with BCD borrows; 00:00 stays 00:00.
  function automatic logic [2*BCD_W-1:0] dec_mmss(input logic [2*BCD_W-1:0] t);
    logic [DIGIT_W-1:0] mt, mu, st, su;
    {mt, mu, st, su} = t;
    if (su != 4'd0) su = su - 4'd1;
    else if (st != 4'd0) begin
      st = st - 4'd1;
      su = MAX_DIGIT;
    end else if (mu != 4'd0 || mt != 4'd0) begin
      st = MAX_TENS;
      su = MAX_DIGIT;
      if (mu != 4'd0) mu = mu - 4'd1;
      else begin
        mt = mt - 4'd1;
        mu = MAX_DIGIT;
      end
    end
    return {mt, mu, st, su};
  endfunction
endpackage

// File: rtl/edge_sync.sv
// edge_sync: synchronizes an asynchronous level and emits a registered one-cycle pulse on its rising edge
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic sig,
  output logic pulse
);
  logic [SYNC_STAGES-1:0] sync;
  logic hist;
  // Shift through the synchronizer, keep one history bit, pulse on 0->1
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      hist  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], sig};
      hist  <= sync[SYNC_STAGES-1];
      pulse <= sync[SYNC_STAGES-1] & ~hist;
    end
  end
endmodule

// File: rtl/tick_countdown.sv
// tick_countdown: mm:ss BCD countdown advanced by synchronized slow_clk ticks
module tick_countdown
  import egg_timer_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             slow_clk,
  input  logic             load,
  input  logic [BCD_W-1:0] preset_min,
  input  logic [BCD_W-1:0] preset_sec,
  input  logic             start,
  input  logic             stop,
  output logic [BCD_W-1:0] min_bcd,
  output logic [BCD_W-1:0] sec_bcd,
  output logic             running,
  output logic             done,
  output logic             tick
);
  state_t state;
  logic [2*BCD_W-1:0] next_count;
  logic [BCD_W-1:0] clamp_min, clamp_sec;
  assign next_count = dec_mmss({min_bcd, sec_bcd});
  assign clamp_min = {clamp_digit(preset_min[7:4], MAX_DIGIT), clamp_digit(preset_min[3:0], MAX_DIGIT)};
  assign clamp_sec = {clamp_digit(preset_sec[7:4], MAX_TENS), clamp_digit(preset_sec[3:0], MAX_DIGIT)};
  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_in(clk_in),
    .rst_n (rst_n),
    .sig   (slow_clk),
    .pulse (tick)
  );
  // Control FSM: load > stop > start > tick, with registered status flags
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      min_bcd <= '0;
      sec_bcd <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else if (load) begin
      state   <= IDLE;
      min_bcd <= clamp_min;
      sec_bcd <= clamp_sec;
      running <= 1'b0;
      done    <= 1'b0;
    end else if (stop) begin
      if (state == RUN) begin
        state   <= PAUSE;
        running <= 1'b0;
      end
    end else if (start && (state == IDLE || state == PAUSE)) begin
      state   <= ({min_bcd, sec_bcd} != '0) ? RUN : DONE;
      running <= ({min_bcd, sec_bcd} != '0);
      done    <= ({min_bcd, sec_bcd} == '0);
    end else if (tick && state == RUN) begin
      {min_bcd, sec_bcd} <= next_count;
      if (next_count == '0) begin
        state   <= DONE;
        running <= 1'b0;
        done    <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_tick_countdown.sv
// tb_tick_countdown: directed self-checking bench for tick_countdown
module tb_tick_countdown;
  logic clk_in = 1'b0;
  logic rst_n = 1'b0;
  logic slow_clk = 1'b0;
  logic load = 1'b0;
  logic [7:0] preset_min = 8'h00;
  logic [7:0] preset_sec = 8'h00;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic [7:0] min_bcd, sec_bcd;
  logic running, done, tick;
  int checks = 0;
  int errors = 0;
  int exp_sec [6] = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'h59};
  int exp_min [6] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00};

  tick_countdown #(.SYNC_STAGES(2)) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .slow_clk  (slow_clk),
    .load      (load),
    .preset_min(preset_min),
    .preset_sec(preset_sec),
    .start     (start),
    .stop      (stop),
    .min_bcd   (min_bcd),
    .sec_bcd   (sec_bcd),
    .running   (running),
    .done      (done),
    .tick      (tick)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [7:0] m, input logic [7:0] s);
    @(negedge clk_in);
    preset_min = m;
    preset_sec = s;
    load = 1'b1;
    @(negedge clk_in);
    load = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk_in);
    start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
  endtask

  task automatic slow_rise();
    @(negedge clk_in);
    slow_clk = 1'b1;
    repeat (4) @(negedge clk_in);
    slow_clk = 1'b0;
    repeat (4) @(negedge clk_in);
  endtask

  initial begin
    repeat (2) @(negedge clk_in);
    chk("rst_min", min_bcd, 8'h00);
    chk("rst_sec", sec_bcd, 8'h00);
    chk("rst_running", running, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_tick", tick, 1'b0);
    rst_n = 1'b1;

    do_load(8'hAB, 8'h7C);
    chk("clamp_min", min_bcd, 8'h99);
    chk("clamp_sec", sec_bcd, 8'h59);
    do_load(8'h00, 8'h00);
    pulse_start();
    chk("zero_start_done", done, 1'b1);
    chk("zero_start_running", running, 1'b0);
    pulse_start();
    @(negedge clk_in);
    stop = 1'b1;
    @(negedge clk_in);
    stop = 1'b0;
    chk("done_sticky", done, 1'b1);
    do_load(8'h01, 8'h05);
    chk("load_clears_done", done, 1'b0);

    pulse_start();
    chk("run_running", running, 1'b1);
    for (int i = 0; i < 6; i++) begin
      slow_rise();
      chk($sformatf("cnt_sec_%0d", i), sec_bcd, exp_sec[i]);
      chk($sformatf("cnt_min_%0d", i), min_bcd, exp_min[i]);
      chk($sformatf("cnt_running_%0d", i), running, 1'b1);
    end

    do_load(8'h00, 8'h02);
    pulse_start();
    slow_rise();
    chk("end_sec_1", sec_bcd, 8'h01);
    chk("end_done_1", done, 1'b0);
    slow_rise();
    chk("end_sec_0", sec_bcd, 8'h00);
    chk("end_min_0", min_bcd, 8'h00);
    chk("end_done", done, 1'b1);
    chk("end_running", running, 1'b0);
    slow_rise();
    chk("end_nowrap_sec", sec_bcd, 8'h00);
    chk("end_nowrap_min", min_bcd, 8'h00);

    do_load(8'h00, 8'h10);
    pulse_start();
    @(negedge clk_in);
    slow_clk = 1'b1;
    repeat (3) @(negedge clk_in);
    chk("stop_tick_high", tick, 1'b1);
    stop = 1'b1;
    @(negedge clk_in);
    stop = 1'b0;
    chk("pause_sec", sec_bcd, 8'h10);
    chk("pause_running", running, 1'b0);
    chk("pause_done", done, 1'b0);
    slow_clk = 1'b0;
    repeat (4) @(negedge clk_in);
    slow_rise();
    chk("pause_tick_ignored", sec_bcd, 8'h10);
    pulse_start();
    chk("resume_running", running, 1'b1);
    slow_rise();
    chk("resume_sec", sec_bcd, 8'h09);

    @(negedge clk_in);
    slow_clk = 1'b1;
    @(posedge clk_in); #1;
    chk("lat_edge1", tick, 1'b0);
    @(posedge clk_in); #1;
    chk("lat_edge2", tick, 1'b0);
    @(posedge clk_in); #1;
    chk("lat_edge3", tick, 1'b1);
    @(posedge clk_in); #1;
    chk("lat_edge4", tick, 1'b0);
    chk("lat_sec", sec_bcd, 8'h08);
    @(negedge clk_in);
    slow_clk = 1'b0;
    repeat (4) @(negedge clk_in);

    slow_clk = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    chk("pre_rst_tick", tick, 1'b1);
    chk("pre_rst_running", running, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_tick", tick, 1'b0);
    chk("arst_running", running, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_sec", sec_bcd, 8'h00);
    chk("arst_min", min_bcd, 8'h00);
    @(negedge clk_in);
    rst_n = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    chk("rel_tick", tick, 1'b1);
    @(posedge clk_in); #1;
    chk("rel_tick_width", tick, 1'b0);
    chk("rel_sec", sec_bcd, 8'h00);
    chk("rel_running", running, 1'b0);
    chk("rel_done", done, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
